chan2push: RTL and testbench
============================

CHAN2PUSH -- requirements
Module: chan2push

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port idata  input  WIDTH  channel data in.
REQ-005 SHALL have port ivalid  input  1  channel data valid.
REQ-006 SHALL have port iready  output  1  channel ready, registered.
REQ-007 SHALL have port odata  output  WIDTH  FIFO write data.
REQ-008 SHALL have port owren  output  1  FIFO write enable.
REQ-009 SHALL have port ofull  input  1  FIFO full flag; FIFO ignores writes while high.
REQ-010 SHALL have, with CHAN2PUSH_COUNT_EN only, port ocount  output  16  written-word count, registered.
REQ-011 SHALL use one clock, clock, with reset asynchronous and active-low on resetn.

Function
REQ-012 SHALL transfer an input word on a rising edge iff ivalid && iready.
REQ-013 SHALL transfer an output word on a rising edge iff owren (owren never high while ofull high).
REQ-014 SHALL hold accepted words in a 2-entry internal buffer, in-order, with head pointer, tail pointer and occupancy count (0..2).
REQ-015 SHALL drive owren combinationally as (count != 0) && !ofull; no other combinational input-to-output path.
REQ-016 SHALL drive odata combinationally as the head entry; value don't-care when count == 0.
REQ-017 SHALL compute count_next = count + in_xfer - out_xfer; simultaneous in/out xfer leaves count unchanged and advances both pointers.
REQ-018 SHALL register iready <= (count_next <= 1), so an accepted word always has a free entry.
REQ-019 SHALL give latency of one cycle: a word accepted at edge t is presented with owren high during cycle t+1 if ofull low.
REQ-020 SHALL sustain one word per cycle when ofull stays low and ivalid stays high.
REQ-021 SHALL, when ofull high, hold count, head and odata; accept input only while count < 2.
REQ-022 SHALL wrap pointers 1 -> 0 (1-bit pointers).
REQ-023 SHALL not modify entries other than the tail entry on an input transfer.

Reset
REQ-024 SHALL on resetn low asynchronously set count 0, head 0, tail 0, iready 1, ocount 0; entry contents undefined.
REQ-025 SHALL discard buffered words when reset asserts mid-operation; owren low during reset.
REQ-026 SHALL resume normal operation on the first rising edge after resetn deasserts.

Configuration
REQ-027 SHALL, with CHAN2PUSH_COUNT_EN defined, increment ocount by 1 on every output transfer, wrapping 16'hFFFF -> 16'h0000.
REQ-028 SHALL, without CHAN2PUSH_COUNT_EN, omit port ocount and its counter entirely; all other behaviour identical.

Structure
REQ-029 SHALL place the buffer depth constant (2) and counter width (16) in the shared codebase include, not inline.
REQ-030 SHALL be a single flat module; no sub-module is natural at this size.

Verification
REQ-031 SHALL test reset: resetn low mid-stream with count 2 -> count 0, owren 0, iready 1 immediately, ocount 0.
REQ-032 SHALL test streaming: ivalid high, ofull low, words 0x01..0x10 -> 16 writes in order, one per cycle after 1-cycle latency, ocount 16.
REQ-033 SHALL test backpressure: ofull high while sending 0xA1,0xA2,0xA3 -> iready low after two accepts, owren 0, 0xA3 held at source; ofull low -> writes 0xA1,0xA2,0xA3 in order.
REQ-034 SHALL test simultaneous: count 1, ofull low, ivalid high -> count stays 1, pointers wrap correctly over 10 words, no loss or duplication.
REQ-035 SHALL test ofull toggling every cycle with random ivalid over 1000 words -> scoreboard exact match, owren never high with ofull high.
REQ-036 SHALL test counter wrap (CHAN2PUSH_COUNT_EN): preset 65535 writes then one more -> ocount 0.

Source files
------------

// File: rtl/chan2push_pkg.sv
// Shared constants for the chan2push channel-to-FIFO-push adapter.
// Holds the skid buffer depth and the written-word counter width so that
// the top module and any future users of this block agree on them.
package chan2push_pkg;

  // Number of entries in the internal skid buffer.
  localparam int unsigned DEPTH    = 2;
  // Pointer width for a DEPTH-entry ring (1 bit: wraps 1 -> 0).
  localparam int unsigned PTR_W    = 1;
  // Occupancy counter width; must hold 0..DEPTH.
  localparam int unsigned OCC_W    = 2;
  // Width of the optional written-word counter.
  localparam int unsigned OCOUNT_W = 16;

endpackage

// File: rtl/chan2push.sv
// chan2push: converts a valid/ready channel into FIFO push (write-enable)
// signalling through a 2-entry in-order skid buffer.
// Optional feature: define CHAN2PUSH_COUNT_EN to add the registered 16-bit
// written-word counter output ocount (wraps 16'hFFFF -> 16'h0000).
// iready is registered: it is computed from next-cycle occupancy, so any
// word accepted while iready is high always has a free entry.
module chan2push
  import chan2push_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] idata,
  input  logic             ivalid,
  output logic             iready,
  output logic [WIDTH-1:0] odata,
  output logic             owren,
  input  logic             ofull
`ifdef CHAN2PUSH_COUNT_EN
  ,
  output logic [OCOUNT_W-1:0] ocount
`endif
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             iready_q, iready_d;
  logic             in_xfer;
  logic             out_xfer;

  // Transfer qualifiers and the push-side outputs (the only combinational paths).
  always_comb begin
    in_xfer  = ivalid && iready_q;
    owren    = (count_q != '0) && !ofull;
    out_xfer = owren;
    odata    = mem_q[head_q];
    iready   = iready_q;
  end

  // Next-state for pointers, occupancy and the registered ready.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (in_xfer) begin
      tail_d = tail_q + PTR_W'(1);
    end
    if (out_xfer) begin
      head_d = head_q + PTR_W'(1);
    end
    if (in_xfer && !out_xfer) begin
      count_d = count_q + OCC_W'(1);
    end else if (!in_xfer && out_xfer) begin
      count_d = count_q - OCC_W'(1);
    end
    iready_d = (count_d <= OCC_W'(1));
  end

  // Control state register; reset empties the buffer and opens the channel.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      iready_q <= 1'b1;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      iready_q <= iready_d;
    end
  end

  // Buffer storage: only the tail entry is written, contents are not reset.
  always_ff @(posedge clock) begin
    if (in_xfer) begin
      mem_q[tail_q] <= idata;
    end
  end

`ifdef CHAN2PUSH_COUNT_EN
  logic [OCOUNT_W-1:0] ocount_q;

  // Written-word counter: one increment per FIFO write, natural wrap.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ocount_q <= '0;
    end else if (out_xfer) begin
      ocount_q <= ocount_q + OCOUNT_W'(1);
    end
  end

  assign ocount = ocount_q;
`endif

endmodule

// File: tb/tb_chan2push.sv
// Directed self-checking bench for chan2push. Counter checks are compiled
// in when CHAN2PUSH_COUNT_EN is defined.
module tb_chan2push;

  localparam int WIDTH = 8;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic [WIDTH-1:0] idata = '0;
  logic             ivalid = 1'b0;
  logic             iready;
  logic [WIDTH-1:0] odata;
  logic             owren;
  logic             ofull = 1'b0;
`ifdef CHAN2PUSH_COUNT_EN
  logic [15:0]      ocount;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] wr_q [$];
  int viol = 0;

  chan2push #(.WIDTH(WIDTH)) dut (
    .clock  (clock),
    .resetn (resetn),
    .idata  (idata),
    .ivalid (ivalid),
    .iready (iready),
    .odata  (odata),
    .owren  (owren),
    .ofull  (ofull)
`ifdef CHAN2PUSH_COUNT_EN
    ,
    .ocount (ocount)
`endif
  );

  always #5 clock = ~clock;

  // Record every FIFO write (inputs are stable between edges).
  always @(negedge clock) begin
    if (owren) wr_q.push_back(odata);
    if (owren && ofull) viol++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    ivalid = 1'b0;
    ofull  = 1'b0;
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    wr_q.delete();
    viol = 0;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    n_checks++;
    if (iready !== 1'b1) begin n_fail++; $display("FAIL reset_iready: got %b expected 1", iready); end
    n_checks++;
    if (owren !== 1'b0) begin n_fail++; $display("FAIL reset_owren: got %b expected 0", owren); end
`ifdef CHAN2PUSH_COUNT_EN
    n_checks++;
    if (ocount !== 16'h0000) begin n_fail++; $display("FAIL reset_ocount: got %h expected 0000", ocount); end
`endif
    // Fill both entries while the FIFO is full.
    tick();
    ofull = 1'b1; ivalid = 1'b1; idata = 8'h11;
    tick();
    idata = 8'h22;
    tick();
    ivalid = 1'b0;
    #1;
    n_checks++;
    if (iready !== 1'b0) begin n_fail++; $display("FAIL reset_full_iready: got %b expected 0", iready); end
    ofull = 1'b0;
    #1;
    n_checks++;
    if (owren !== 1'b1 || odata !== 8'h11) begin
      n_fail++; $display("FAIL reset_prefill_head: got owren=%b odata=%h expected 1/11", owren, odata);
    end
    // Asynchronous reset mid-cycle with two words buffered.
    resetn = 1'b0;
    #1;
    n_checks++;
    if (owren !== 1'b0) begin n_fail++; $display("FAIL reset_mid_owren: got %b expected 0", owren); end
    n_checks++;
    if (iready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_iready: got %b expected 1", iready); end
`ifdef CHAN2PUSH_COUNT_EN
    n_checks++;
    if (ocount !== 16'h0000) begin n_fail++; $display("FAIL reset_mid_ocount: got %h expected 0000", ocount); end
`endif
    tick();
    resetn = 1'b1;
    tick();
    n_checks++;
    if (owren !== 1'b0) begin n_fail++; $display("FAIL reset_discard: got owren=%b expected 0", owren); end
    ivalid = 1'b1; idata = 8'h33;
    tick();
    ivalid = 1'b0;
    #1;
    n_checks++;
    if (owren !== 1'b1 || odata !== 8'h33) begin
      n_fail++; $display("FAIL reset_resume: got owren=%b odata=%h expected 1/33", owren, odata);
    end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_streaming;
    do_reset();
    ofull = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      idata = 8'(i); ivalid = 1'b1;
      #1;
      n_checks++;
      if (i == 1) begin
        if (owren !== 1'b0) begin n_fail++; $display("FAIL stream_first_owren: got %b expected 0", owren); end
      end else if (owren !== 1'b1 || odata !== 8'(i - 1) || iready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_cycle%0d: got owren=%b odata=%h iready=%b expected 1/%h/1", i, owren, odata, iready, 8'(i - 1));
      end
      tick();
    end
    ivalid = 1'b0;
    #1;
    n_checks++;
    if (owren !== 1'b1 || odata !== 8'h10) begin
      n_fail++; $display("FAIL stream_last: got owren=%b odata=%h expected 1/10", owren, odata);
    end
    tick();
    n_checks++;
    if (owren !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got owren=%b expected 0", owren); end
    n_checks++;
    if (wr_q.size() != 16) begin n_fail++; $display("FAIL stream_nwrites: got %0d expected 16", wr_q.size()); end
    else begin
      for (int k = 0; k < 16; k++) begin
        n_checks++;
        if (wr_q[k] !== 8'(k + 1)) begin n_fail++; $display("FAIL stream_word%0d: got %h expected %h", k, wr_q[k], 8'(k + 1)); end
      end
    end
`ifdef CHAN2PUSH_COUNT_EN
    n_checks++;
    if (ocount !== 16'd16) begin n_fail++; $display("FAIL stream_ocount: got %0d expected 16", ocount); end
`endif
    $display("test_streaming done: %0d writes", wr_q.size());
  endtask

  task automatic test_backpressure;
    do_reset();
    ofull = 1'b1; ivalid = 1'b1; idata = 8'hA1;
    #1;
    n_checks++;
    if (iready !== 1'b1 || owren !== 1'b0) begin
      n_fail++; $display("FAIL bp_a1: got iready=%b owren=%b expected 1/0", iready, owren);
    end
    tick();
    idata = 8'hA2;
    #1;
    n_checks++;
    if (iready !== 1'b1 || owren !== 1'b0) begin
      n_fail++; $display("FAIL bp_a2: got iready=%b owren=%b expected 1/0", iready, owren);
    end
    tick();
    idata = 8'hA3;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (iready !== 1'b0 || owren !== 1'b0 || odata !== 8'hA1) begin
        n_fail++; $display("FAIL bp_hold%0d: got iready=%b owren=%b odata=%h expected 0/0/a1", c, iready, owren, odata);
      end
      tick();
    end
    ofull = 1'b0;
    #1;
    n_checks++;
    if (owren !== 1'b1 || odata !== 8'hA1 || iready !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got owren=%b odata=%h iready=%b expected 1/a1/0", owren, odata, iready);
    end
    tick();
    n_checks++;
    if (owren !== 1'b1 || odata !== 8'hA2 || iready !== 1'b1) begin
      n_fail++; $display("FAIL bp_second: got owren=%b odata=%h iready=%b expected 1/a2/1", owren, odata, iready);
    end
    tick();
    ivalid = 1'b0;
    #1;
    n_checks++;
    if (owren !== 1'b1 || odata !== 8'hA3) begin
      n_fail++; $display("FAIL bp_third: got owren=%b odata=%h expected 1/a3", owren, odata);
    end
    tick();
    tick();
    n_checks++;
    if (wr_q.size() != 3 || wr_q[0] !== 8'hA1 || wr_q[1] !== 8'hA2 || wr_q[2] !== 8'hA3) begin
      n_fail++; $display("FAIL bp_order: got %0d writes expected a1,a2,a3", wr_q.size());
    end
    $display("test_backpressure done: %0d writes", wr_q.size());
  endtask

  task automatic test_simultaneous;
    do_reset();
    ofull = 1'b0; ivalid = 1'b1; idata = 8'h50;
    tick();
    for (int i = 1; i < 10; i++) begin
      idata = 8'(8'h50 + i);
      #1;
      n_checks++;
      if (iready !== 1'b1 || owren !== 1'b1 || odata !== 8'(8'h50 + i - 1)) begin
        n_fail++;
        $display("FAIL simul_cycle%0d: got iready=%b owren=%b odata=%h expected 1/1/%h", i, iready, owren, odata, 8'(8'h50 + i - 1));
      end
      tick();
    end
    ivalid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (wr_q.size() != 10) begin n_fail++; $display("FAIL simul_nwrites: got %0d expected 10", wr_q.size()); end
    else begin
      for (int k = 0; k < 10; k++) begin
        n_checks++;
        if (wr_q[k] !== 8'(8'h50 + k)) begin n_fail++; $display("FAIL simul_word%0d: got %h expected %h", k, wr_q[k], 8'(8'h50 + k)); end
      end
    end
    $display("test_simultaneous done: %0d writes", wr_q.size());
  endtask

  task automatic test_ofull_toggle;
    int sent = 0;
    int cyc = 0;
    int bad = -1;
    do_reset();
    while ((sent < 1000 || wr_q.size() < 1000) && cyc < 8000) begin
      ofull = ~ofull;
      if (sent < 1000) begin
        ivalid = 1'($urandom_range(0, 1));
        idata  = sent[7:0];
      end else begin
        ivalid = 1'b0;
      end
      #1;
      if (ivalid && iready) sent++;
      tick();
      cyc++;
    end
    ivalid = 1'b0;
    ofull  = 1'b0;
    tick();
    tick();
    n_checks++;
    if (cyc >= 8000) begin n_fail++; $display("FAIL toggle_timeout: got sent=%0d writes=%0d expected 1000/1000", sent, wr_q.size()); end
    n_checks++;
    if (wr_q.size() != 1000) begin n_fail++; $display("FAIL toggle_nwrites: got %0d expected 1000", wr_q.size()); end
    for (int k = 0; k < wr_q.size() && k < 1000; k++) begin
      if (bad < 0 && wr_q[k] !== 8'(k)) bad = k;
    end
    n_checks++;
    if (bad >= 0) begin n_fail++; $display("FAIL toggle_order: word %0d got %h expected %h", bad, wr_q[bad], 8'(bad)); end
    n_checks++;
    if (viol != 0) begin n_fail++; $display("FAIL toggle_owren_while_full: got %0d expected 0", viol); end
`ifdef CHAN2PUSH_COUNT_EN
    n_checks++;
    if (ocount !== 16'd1000) begin n_fail++; $display("FAIL toggle_ocount: got %0d expected 1000", ocount); end
`endif
    $display("test_ofull_toggle done: %0d writes in %0d cycles", wr_q.size(), cyc);
  endtask

`ifdef CHAN2PUSH_COUNT_EN
  task automatic test_counter_wrap;
    int acc = 0;
    int cyc = 0;
    do_reset();
    ofull = 1'b0; ivalid = 1'b1;
    while (acc < 65535 && cyc < 70000) begin
      idata = acc[7:0];
      #1;
      if (iready) acc++;
      tick();
      cyc++;
    end
    ivalid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (ocount !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preset: got %h expected ffff", ocount); end
    ivalid = 1'b1;
    tick();
    ivalid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (ocount !== 16'h0000) begin n_fail++; $display("FAIL wrap_rollover: got %h expected 0000", ocount); end
    wr_q.delete();
    $display("test_counter_wrap done");
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_ofull_toggle();
`ifdef CHAN2PUSH_COUNT_EN
    test_counter_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
